elbeth_mem_responder: RTL
=========================

ELBETH_MEM_RESPONDER -- requirements
Module: elbeth_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: word-address bits; storage depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles inserted before a successful response (legal range 0..15).
REQ-003 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port mem_en, input, 1: initiator request valid; held high with stable fields until mem_ready.
REQ-006 Port mem_addr, input, 32: byte address.
REQ-007 Port mem_in_data, input, 32: write data from the initiator.
REQ-008 Port mem_rw, input, 4: byte write strobes; 4'b0000 means read, any nonzero value means write.
REQ-009 Port mem_out_data, output, 32: read data to the initiator.
REQ-010 Port mem_ready, output, 1: one-cycle completion pulse.
REQ-011 Port mem_error, output, 1: error flag, valid only while mem_ready is high.
REQ-012 Port mem_busy, output, 1: transaction in progress, high in WAIT and RESP.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 IDLE: when mem_en=1 at a clock edge, the request SHALL be accepted and the address, strobes and data captured.
REQ-015 Decode at accept: the request is an error when mem_addr[1:0]!=0 (misaligned) or mem_addr[31:ADDR_WIDTH+2]!=0 (out of range).
REQ-016 Error request: go IDLE->RESP; the array is not touched; the response carries mem_error=1 and mem_out_data=0.
REQ-017 Valid write: at the accept edge, byte i of word mem_addr[ADDR_WIDTH+1:2] SHALL take mem_in_data[8i+7:8i] for each mem_rw[i]=1; other bytes are unchanged.
REQ-018 Valid read: the word SHALL be sampled at the accept edge and presented on mem_out_data during RESP.
REQ-019 Valid request with WAIT_STATES=0: go IDLE->RESP.
REQ-020 Valid request with WAIT_STATES>0: go IDLE->WAIT; the wait counter is loaded with WAIT_STATES-1, and WAIT->RESP occurs when the counter reaches 0.
REQ-021 Latency: mem_ready SHALL go high exactly WAIT_STATES+1 cycles after the accept edge for valid requests, and 1 cycle after for error requests.
REQ-022 RESP SHALL last exactly one cycle, with mem_ready=1, and then return to IDLE unconditionally.
REQ-023 Request sampling: mem_en still high during RESP SHALL NOT be sampled; mem_en is only sampled in IDLE, so the minimum spacing between accepts is WAIT_STATES+2 cycles.
REQ-024 An accepted transaction is committed: mem_en dropping during WAIT SHALL NOT cancel it, and the RESP pulse still occurs.
REQ-025 mem_out_data SHALL hold its last read value; write responses leave it unchanged, error responses set it to 0.
REQ-026 mem_error SHALL be 0 whenever mem_ready=0.
REQ-027 A write followed by a read of the same word SHALL return the merged written value.

Reset
REQ-028 On rst=1, the block SHALL immediately enter IDLE, with mem_ready=0, mem_error=0, mem_busy=0, mem_out_data=0 and the wait counter at 0.
REQ-029 Reset mid-transaction SHALL discard the pending response; an already committed write SHALL remain in the array.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 The first accept after reset release SHALL occur at the first rising edge with rst=0 and mem_en=1.

Structure
REQ-032 FSM state encodings and the strobe "read" code (4'b0000) SHALL live in the shared elbeth definitions file used by the core and memory.
REQ-033 Byte-enabled storage SHALL be a sub-module elbeth_ram_array, parameterized by ADDR_WIDTH, with a 4-bit write enable and a synchronous write and read port.
REQ-034 The FSM, wait counter and error decode SHALL reside in elbeth_mem_responder.

Verification
REQ-035 WAIT_STATES=1: write addr 0x10, data 0xDEADBEEF, rw=4'hF -> mem_ready high 2 cycles after accept with error=0; then read 0x10 -> mem_out_data=0xDEADBEEF.
REQ-036 Partial write 0x10, rw=4'b0010, data 0x0000AA00 -> a subsequent read returns 0xDEADAAEF.
REQ-037 Read 0x13 (misaligned) and read 0x400 with ADDR_WIDTH=8 -> each gives ready 1 cycle after accept, error=1, out_data=0, and the array is unchanged.
REQ-038 WAIT_STATES=0 with mem_en held high continuously -> accepts every 2 cycles, ready pulses every 2 cycles, never two consecutive ready cycles.
REQ-039 WAIT_STATES=3: assert rst during WAIT of a write to 0x20 -> ready never pulses, all outputs are 0 after reset, and a later read of 0x20 returns the written data.
REQ-040 WAIT_STATES=2: drop mem_en one cycle after accept -> ready still pulses 3 cycles after accept.

Source files
------------

// File: rtl/elbeth_pkg.sv
// elbeth_pkg -- shared definitions for the elbeth memory responder slice.
// Contents:
//   state_t  : responder FSM state encoding (IDLE, WAIT, RESP)
//   RW_READ  : strobe code that marks a request as a read
//   WORD_W   : storage word width in bits
//   CNT_W    : wait-state counter width (covers WAIT_STATES up to 15)
package elbeth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] RW_READ = 4'b0000;
  localparam int         WORD_W  = 32;
  localparam int         CNT_W   = 4;

endpackage

// File: rtl/elbeth_ram_array.sv
// elbeth_ram_array -- byte-enabled single-port storage, 2^ADDR_WIDTH words.
// Ports:
//   clk     : rising-edge clock
//   addr    : word address
//   we      : per-byte write enable (bit i writes byte i)
//   wr_data : write data
//   rd_en   : load rd_data from the addressed word at this edge
//   rd_data : registered read data, holds until the next rd_en
// Contents are never reset.
module elbeth_ram_array
  import elbeth_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [WORD_W-1:0]     rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/elbeth_mem_responder.sv
// elbeth_mem_responder -- memory-mapped responder with configurable wait states.
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   mem_en       : request valid, held with stable fields until mem_ready
//   mem_addr     : byte address
//   mem_in_data  : write data
//   mem_rw       : byte strobes, 4'b0000 = read
//   mem_out_data : read data, holds last read value (0 after error/reset)
//   mem_ready    : one-cycle completion pulse
//   mem_error    : error flag, only asserted alongside mem_ready
//   mem_busy     : high in WAIT and RESP
// Requests are sampled only in IDLE. Writes commit at the accept edge, reads
// are sampled at the accept edge, so the wait states only delay the response.
module elbeth_mem_responder
  import elbeth_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_in_data,
  input  logic [3:0]        mem_rw,
  output logic [31:0]       mem_out_data,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              mem_busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              out_vld_q, out_vld_d;
  logic              accept;
  logic              addr_err;
  logic              is_read;
  logic [WORD_W-1:0] ram_rd;

  assign accept   = (state_q == ST_IDLE) && mem_en;
  assign addr_err = (mem_addr[1:0] != 2'b00) ||
                    ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign is_read  = (mem_rw == RW_READ);

  // Array access happens on the accept edge; error requests never touch it.
  elbeth_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .addr    (mem_addr[ADDR_WIDTH+1:2]),
    .we      ((accept && !addr_err) ? mem_rw : 4'b0000),
    .wr_data (mem_in_data),
    .rd_en   (accept && !addr_err && is_read),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_vld_d = out_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          err_d = addr_err;
          if (addr_err) begin
            out_vld_d = 1'b0;
            state_d   = ST_RESP;
          end else begin
            // out_vld selects the RAM read register; writes leave it alone
            // so the previous read value keeps being presented.
            if (is_read) out_vld_d = 1'b1;
            if (WAIT_STATES == 0) begin
              state_d = ST_RESP;
            end else begin
              cnt_d   = WAIT_LOAD;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_ready    = (state_q == ST_RESP);
  assign mem_error    = (state_q == ST_RESP) && err_q;
  assign mem_busy     = (state_q == ST_WAIT) || (state_q == ST_RESP);
  assign mem_out_data = out_vld_q ? ram_rd : 32'd0;

endmodule
